// File: rtl/div_rem_unit_if.sv
// Bundle between the control unit and the divide/remainder unit.
// Operands, op select, control state in; result, done pulse, busy out.
interface div_rem_unit_if;
  logic [31:0] i_state;
  logic [31:0] i_instruction;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic [31:0] o_result;
  logic        o_finnished;
  logic        o_busy;

  modport master (
    output i_state,
    output i_instruction,
    output i_rs1,
    output i_rs2,
    input  o_result,
    input  o_finnished,
    input  o_busy
  );

  modport slave (
    input  i_state,
    input  i_instruction,
    input  i_rs1,
    input  i_rs2,
    output o_result,
    output o_finnished,
    output o_busy
  );
endinterface

// File: rtl/div_rem_unit.sv
// Iterative 32-bit DIV/DIVU/REM/REMU unit (restoring, 1 bit/cycle).
// Ports: i_clk, i_rst (async high), bus (slave: ops in, result out).
module div_rem_unit #(
  parameter int DIV_LATENCY_CHECK = 0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  div_rem_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [31:0] ST_EXEC = 32'd1;
  localparam logic [31:0] OP_DIV  = 32'd14;
  localparam logic [31:0] OP_DIVU = 32'd15;
  localparam logic [31:0] OP_REM  = 32'd16;
  localparam logic [31:0] OP_REMU = 32'd17;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] ALL_ONE = 32'hFFFF_FFFF;

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_div;
  logic        r_qsign;
  logic        r_rsign;
  logic        r_is_rem;
  logic [31:0] r_result;

  logic        w_exec;
  logic        w_is_op;
  logic        w_signed;
  logic        w_rem_op;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic        w_dz;
  logic        w_ovf;
  logic        w_fast;
  logic        w_start;
  logic [31:0] w_fast_res;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_quo_nxt;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  // Op decode
  always_comb begin
    w_is_op  = 1'b0;
    w_signed = 1'b0;
    w_rem_op = 1'b0;
    unique case (1'b1)
      (bus.i_instruction == OP_DIV): begin
        w_is_op  = 1'b1;
        w_signed = 1'b1;
      end
      (bus.i_instruction == OP_DIVU): begin
        w_is_op  = 1'b1;
      end
      (bus.i_instruction == OP_REM): begin
        w_is_op  = 1'b1;
        w_signed = 1'b1;
        w_rem_op = 1'b1;
      end
      (bus.i_instruction == OP_REMU): begin
        w_is_op  = 1'b1;
        w_rem_op = 1'b1;
      end
      default: begin
        w_is_op  = 1'b0;
      end
    endcase
  end

  assign w_exec  = (bus.i_state == ST_EXEC);
  assign w_a_neg = w_signed & bus.i_rs1[31];
  assign w_b_neg = w_signed & bus.i_rs2[31];
  assign w_abs_a = w_a_neg ? (32'd0 - bus.i_rs1)
                           : bus.i_rs1;
  assign w_abs_b = w_b_neg ? (32'd0 - bus.i_rs2)
                           : bus.i_rs2;

  assign w_dz  = (bus.i_rs2 == 32'd0);
  assign w_ovf = w_signed
               & (bus.i_rs1 == INT_MIN)
               & (bus.i_rs2 == ALL_ONE);
  assign w_fast = w_dz | w_ovf;

  assign w_start = (r_state == S_IDLE)
                 & w_exec & w_is_op;

  // Divide-by-zero remainder is the raw dividend,
  // not its magnitude.
  always_comb begin
    w_fast_res = 32'd0;
    if (w_dz) begin
      w_fast_res = w_rem_op ? bus.i_rs1 : ALL_ONE;
    end else begin
      w_fast_res = w_rem_op ? 32'd0 : INT_MIN;
    end
  end

  // One restoring step: 33-bit working remainder
  // takes the next dividend bit from the quotient MSB.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_diff  = w_shift - {1'b0, r_div};
  assign w_ge    = ~w_diff[32];
  assign w_rem_nxt = w_ge ? w_diff[31:0]
                          : w_shift[31:0];
  assign w_quo_nxt = {r_quo[30:0], w_ge};

  assign w_q_fix = r_qsign ? (32'd0 - r_quo) : r_quo;
  assign w_r_fix = r_rsign ? (32'd0 - r_rem) : r_rem;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next = w_fast ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (!w_exec) begin
          w_next = S_IDLE;
        end else if (r_cnt == 6'd31) begin
          w_next = S_FIX;
        end
      end
      S_FIX: begin
        w_next = w_exec ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt    <= 6'd0;
      r_rem    <= 32'd0;
      r_quo    <= 32'd0;
      r_div    <= 32'd0;
      r_qsign  <= 1'b0;
      r_rsign  <= 1'b0;
      r_is_rem <= 1'b0;
      r_result <= 32'd0;
    end else if (w_start) begin
      r_cnt    <= 6'd0;
      r_rem    <= 32'd0;
      r_quo    <= w_abs_a;
      r_div    <= w_abs_b;
      r_qsign  <= w_a_neg ^ w_b_neg;
      r_rsign  <= w_a_neg;
      r_is_rem <= w_rem_op;
      if (w_fast) begin
        r_result <= w_fast_res;
      end
    end else if (r_state == S_CALC && w_exec) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + 6'd1;
    end else if (r_state == S_FIX && w_exec) begin
      r_result <= r_is_rem ? w_r_fix : w_q_fix;
    end
  end

  assign bus.o_result    = r_result;
  assign bus.o_finnished = (r_state == S_DONE);
  assign bus.o_busy      = (r_state != S_IDLE);

  generate
    if (DIV_LATENCY_CHECK != 0) begin : g_chk
      a_fin_in_exec: assert property (
        @(posedge i_clk) disable iff (i_rst)
        bus.o_finnished |-> (bus.i_state == ST_EXEC)
      );
    end
  endgenerate

endmodule

// File: tb/tb_div_rem_unit.sv
// Directed bench for div_rem_unit.
// Drives ops through the bus interface, checks result and timing.
module tb_div_rem_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  div_rem_unit_if bus ();

  div_rem_unit #(
    .DIV_LATENCY_CHECK(1)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic run_op(
    input  logic [31:0] ins,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  bit          scramble,
    output int          lat,
    output logic [31:0] res,
    output logic        fin2,
    output logic        busy2
  );
    @(negedge clk);
    bus.i_state       = 32'd1;
    bus.i_instruction = ins;
    bus.i_rs1         = a;
    bus.i_rs2         = b;
    @(posedge clk);
    #1;
    lat = 1;
    while (bus.o_finnished !== 1'b1 && lat < 60) begin
      if (scramble) begin
        bus.i_rs1 = $urandom;
        bus.i_rs2 = $urandom;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    res = bus.o_result;
    @(posedge clk);
    #1;
    fin2  = bus.o_finnished;
    busy2 = bus.o_busy;
    bus.i_state = 32'd0;
  endtask

  task automatic test_reset;
    bus.i_state       = 32'd1;
    bus.i_instruction = 32'd14;
    bus.i_rs1         = 32'd77;
    bus.i_rs2         = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b want 0", bus.o_busy);
    end
    n_cmp++;
    if (bus.o_finnished !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fin got %b want 0", bus.o_finnished);
    end
    n_cmp++;
    if (bus.o_result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_result got %h want 0", bus.o_result);
    end
    // first edge after release must accept a start
    @(negedge clk);
    rst = 1'b0;
    bus.i_instruction = 32'd15;
    bus.i_rs1         = 32'd9;
    bus.i_rs2         = 32'd0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.o_finnished !== 1'b1 ||
        bus.o_result !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL first_start fin=%b res=%h want 1 ffffffff",
               bus.o_finnished, bus.o_result);
    end
    @(posedge clk);
    #1;
    bus.i_state = 32'd0;
  endtask

  task automatic test_signed;
    vec_t v[6];
    int lat;
    logic [31:0] res;
    logic f2, b2;
    v = '{
      '{32'd14, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD},
      '{32'd16, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF},
      '{32'd14, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD},
      '{32'd16, 32'd7,         32'hFFFF_FFFE, 32'd1},
      '{32'd16, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF},
      '{32'd14, 32'h8000_0000, 32'd2,        32'hC000_0000}
    };
    for (int i = 0; i < 6; i++) begin
      run_op(v[i].ins, v[i].a, v[i].b, 1'b0, lat, res, f2, b2);
      n_cmp++;
      if (res !== v[i].exp || lat != 34) begin
        n_fail++;
        $display("FAIL signed[%0d] res=%h lat=%0d want %h 34",
                 i, res, lat, v[i].exp);
      end
      n_cmp++;
      if (f2 !== 1'b0 || b2 !== 1'b0) begin
        n_fail++;
        $display("FAIL signed_pulse[%0d] fin=%b busy=%b want 0 0",
                 i, f2, b2);
      end
    end
  endtask

  task automatic test_unsigned;
    vec_t v[6];
    int lat;
    logic [31:0] res;
    logic f2, b2;
    v = '{
      '{32'd15, 32'hFFFF_FFFF, 32'h10,       32'h0FFF_FFFF},
      '{32'd17, 32'hFFFF_FFFF, 32'h10,       32'hF},
      '{32'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0},
      '{32'd17, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
      '{32'd15, 32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC},
      '{32'd17, 32'hFFFF_FFF9, 32'd2,        32'd1}
    };
    for (int i = 0; i < 6; i++) begin
      run_op(v[i].ins, v[i].a, v[i].b, 1'b0, lat, res, f2, b2);
      n_cmp++;
      if (res !== v[i].exp || lat != 34) begin
        n_fail++;
        $display("FAIL unsigned[%0d] res=%h lat=%0d want %h 34",
                 i, res, lat, v[i].exp);
      end
      n_cmp++;
      if (f2 !== 1'b0) begin
        n_fail++;
        $display("FAIL unsigned_pulse[%0d] fin=%b want 0", i, f2);
      end
    end
  endtask

  task automatic test_fast_path;
    vec_t v[7];
    int lat;
    logic [31:0] res;
    logic f2, b2;
    v = '{
      '{32'd14, 32'd123,       32'd0,        32'hFFFF_FFFF},
      '{32'd16, 32'd123,       32'd0,        32'd123},
      '{32'd15, 32'd5,         32'd0,        32'hFFFF_FFFF},
      '{32'd17, 32'h8000_0000, 32'd0,        32'h8000_0000},
      '{32'd16, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB},
      '{32'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
      '{32'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0}
    };
    for (int i = 0; i < 7; i++) begin
      run_op(v[i].ins, v[i].a, v[i].b, 1'b0, lat, res, f2, b2);
      n_cmp++;
      if (res !== v[i].exp || lat != 1) begin
        n_fail++;
        $display("FAIL fast[%0d] res=%h lat=%0d want %h 1",
                 i, res, lat, v[i].exp);
      end
      n_cmp++;
      if (f2 !== 1'b0 || b2 !== 1'b0) begin
        n_fail++;
        $display("FAIL fast_pulse[%0d] fin=%b busy=%b want 0 0",
                 i, f2, b2);
      end
    end
  endtask

  task automatic test_operand_hold;
    int lat;
    logic [31:0] res;
    logic f2, b2;
    run_op(32'd15, 32'd100, 32'd7, 1'b1, lat, res, f2, b2);
    n_cmp++;
    if (res !== 32'd14 || lat != 34) begin
      n_fail++;
      $display("FAIL operand_hold res=%h lat=%0d want 0000000e 34",
               res, lat);
    end
  endtask

  task automatic test_integration;
    int lat;
    logic [31:0] res;
    logic f2, b2;
    run_op(32'd14, 32'd200, 32'd8, 1'b0, lat, res, f2, b2);
    n_cmp++;
    if (res !== 32'd25 || lat != 34) begin
      n_fail++;
      $display("FAIL integ_div res=%h lat=%0d want 00000019 34",
               res, lat);
    end
    // instruction still reads DIV, but state is FETCH
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL no_restart busy=%b want 0", bus.o_busy);
    end
    // ADD in EXECUTE must not wake the divider
    @(negedge clk);
    bus.i_state       = 32'd1;
    bus.i_instruction = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.o_busy !== 1'b0 || bus.o_finnished !== 1'b0) begin
        n_fail++;
        $display("FAIL add_idle[%0d] busy=%b fin=%b want 0 0",
                 i, bus.o_busy, bus.o_finnished);
      end
    end
    bus.i_state = 32'd0;
  endtask

  task automatic test_abort;
    int lat;
    logic [31:0] res;
    logic f2, b2;
    bit seen;
    run_op(32'd15, 32'd50, 32'd5, 1'b0, lat, res, f2, b2);
    n_cmp++;
    if (res !== 32'd10) begin
      n_fail++;
      $display("FAIL abort_pre res=%h want 0000000a", res);
    end
    @(negedge clk);
    bus.i_state       = 32'd1;
    bus.i_instruction = 32'd14;
    bus.i_rs1         = 32'd1000;
    bus.i_rs2         = 32'd3;
    repeat (5) @(posedge clk);
    #1;
    bus.i_state = 32'd0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle busy=%b want 0", bus.o_busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_finnished === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_fin seen=%b want 0", seen);
    end
    n_cmp++;
    if (bus.o_result !== 32'd10) begin
      n_fail++;
      $display("FAIL abort_result got %h want 0000000a",
               bus.o_result);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [31:0] res;
    logic f2, b2;
    bit seen;
    @(negedge clk);
    bus.i_state       = 32'd1;
    bus.i_instruction = 32'd15;
    bus.i_rs1         = 32'd100;
    bus.i_rs2         = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy got %b want 1", bus.o_busy);
    end
    rst = 1'b1;
    bus.i_state = 32'd0;
    #1;
    n_cmp++;
    if (bus.o_busy !== 1'b0 || bus.o_result !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_reset busy=%b res=%h want 0 0",
               bus.o_busy, bus.o_result);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_finnished === 1'b1 || bus.o_busy === 1'b1)
        seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_pulse seen=%b want 0", seen);
    end
    run_op(32'd15, 32'd100, 32'd7, 1'b0, lat, res, f2, b2);
    n_cmp++;
    if (res !== 32'd14 || lat != 34) begin
      n_fail++;
      $display("FAIL after_reset res=%h lat=%0d want 0000000e 34",
               res, lat);
    end
  endtask

  initial begin
    bus.i_state       = 32'd0;
    bus.i_instruction = 32'd0;
    bus.i_rs1         = 32'd0;
    bus.i_rs2         = 32'd0;
    test_reset();
    test_signed();
    test_unsigned();
    test_fast_path();
    test_operand_hold();
    test_integration();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/div_rem_unit.md
DIV_REM_UNIT -- requirements
Module: div_rem_unit

Interface
REQ-001 SHALL have parameter DIV_LATENCY_CHECK, default 0, meaning 1 enables a simulation-only assertion that o_finnished never rises outside EXECUTE.
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_state  input  32  control-unit state (0 FETCH, 1 EXECUTE, 2 MINT, 3 SINT).
REQ-005 SHALL have port i_instruction  input  32  decoded instruction index (14 DIV, 15 DIVU, 16 REM, 17 REMU).
REQ-006 SHALL have port i_rs1  input  32  dividend.
REQ-007 SHALL have port i_rs2  input  32  divisor.
REQ-008 SHALL have port o_result  output  32  quotient or remainder.
REQ-009 SHALL have port o_finnished  output  1  one-cycle completion pulse consumed by the control unit.
REQ-010 SHALL have port o_busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-012 Start condition: IDLE and i_state==1 and 14<=i_instruction<=17; at that edge i_rs1, i_rs2, op latched; later operand changes ignored.
REQ-013 Signed ops (14, 16) SHALL latch |rs1|, |rs2| plus quotient sign (rs1[31]^rs2[31]) and remainder sign (rs1[31]); unsigned ops (15, 17) latch raw values with both signs 0.
REQ-014 Divide-by-zero (rs2==0) at start SHALL go IDLE->DONE with result: DIV/DIVU 0xFFFFFFFF, REM/REMU rs1.
REQ-015 Signed overflow (op 14 or 16, rs1==0x80000000, rs2==0xFFFFFFFF) SHALL go IDLE->DONE with result: DIV 0x80000000, REM 0.
REQ-016 Otherwise IDLE->CALC with 6-bit iteration counter 0.
REQ-017 CALC SHALL perform one restoring shift-subtract step per cycle (33-bit partial remainder, 32-bit quotient, MSB first) for exactly 32 cycles, counter 0..31, then ->FIX.
REQ-018 FIX SHALL negate quotient when quotient sign set and remainder when remainder sign set, select quotient (14, 15) or remainder (16, 17) into o_result, ->DONE.
REQ-019 DONE SHALL assert o_finnished for exactly one cycle, ->IDLE unconditionally.
REQ-020 Latency: start detected in cycle 0 -> o_finnished high in cycle 34 (normal) or cycle 1 (REQ-014/015 fast path).
REQ-021 o_result SHALL be registered, valid during DONE and held until the next FIX or fast-path DONE.
REQ-022 In IDLE during the cycle after DONE, no restart SHALL occur even if i_instruction still reads 14..17, since i_state is then 0; restart requires i_state==1 again.
REQ-023 If i_state!=1 while in CALC or FIX (abort), SHALL return to IDLE next edge without asserting o_finnished; o_result unchanged.
REQ-024 Non-div/rem instructions in EXECUTE SHALL leave the FSM in IDLE with o_finnished=0.
REQ-025 o_finnished SHALL never be asserted outside DONE.

Reset
REQ-026 While i_rst=1: state IDLE, counter 0, o_result 0, o_finnished 0, o_busy 0, all datapath registers 0, regardless of clock.
REQ-027 Reset asserted mid-CALC SHALL abort immediately; after release, no stale o_finnished pulse.
REQ-028 First start is accepted on the first rising edge with i_rst=0 and REQ-012 satisfied.

Verification
REQ-029 DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> o_finnished in cycle 34, o_result 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1).
REQ-030 DIVU rs1=0xFFFFFFFF, rs2=0x10 -> 0x0FFFFFFF; REMU -> 0xF; o_finnished high exactly one cycle.
REQ-031 DIV rs1=123, rs2=0 -> o_finnished in cycle 1, o_result 0xFFFFFFFF; REM rs1=123, rs2=0 -> 123.
REQ-032 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in cycle 1; REM -> 0.
REQ-033 Start DIVU 100/7, assert i_rst at cycle 10 for 1 cycle -> o_busy 0 immediately, no o_finnished; next start returns 14 in cycle 34.
REQ-034 Integration with control unit: program DIV followed by ADD -> control unit leaves EXECUTE on the o_finnished cycle, ADD executes, divider stays IDLE.
